// File: rtl/guess_pkg.sv
// guess_pkg: shared types and constants for the guess-number game blocks.
//   - digit geometry (DIGIT_W, NUM_DIGITS, MAX_DIGIT)
//   - 12-bit BCD number type used by the target generator and the comparison stage
//   - LFSR width, tap mask and a next-state helper
//   - target generator FSM state enum
package guess_pkg;

    localparam int          DIGIT_W    = 4;
    localparam int          NUM_DIGITS = 3;
    localparam logic [3:0]  MAX_DIGIT  = 4'd9;

    typedef logic [DIGIT_W*NUM_DIGITS-1:0] num_t;

    localparam int          LFSR_W    = 16;
    // x^16+x^14+x^13+x^11+1 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2,
        D3   = 2'd3
    } tg_state_t;

    // Fibonacci shift-left step: XOR of tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/target_gen_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, shifts every cycle.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, loads SEED (all-zero seed becomes 1)
//   state_o - current LFSR state
module lfsr16
    import guess_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    // The all-zero state is a lock-up state for an XOR LFSR.
    localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEED_FIX;
        else     state_q <= lfsr_next(state_q);
    end

    assign state_o = state_q;

endmodule

// File: rtl/target_gen.sv
// target_gen: random 3-digit BCD target generator with rejection sampling.
// Ports:
//   clk           - clock
//   rst           - synchronous active-high reset
//   gen_req       - start a generation (ignored while busy)
//   target_number - last completed target, {digit3, digit2, digit1}
//   target_valid  - target_number holds a completed target
//   busy          - generation in progress
//   draw_count    - candidates examined in current/last generation, saturates at 255
// Build option: define TARGET_GEN_DISTINCT_EN to require pairwise-distinct digits;
// without it the only accept condition is candidate <= 9.
module target_gen
    import guess_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gen_req,
    output num_t       target_number,
    output logic       target_valid,
    output logic       busy,
    output logic [7:0] draw_count
);

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    // Only the low nibble is a candidate; upper bits just keep the sequence long.
    assign lfsr_unused = ^lfsr[LFSR_W-1:DIGIT_W];

    tg_state_t          state_q, state_d;
    logic [DIGIT_W-1:0] dig3_q, dig3_d, dig2_q, dig2_d;
    num_t               tgt_q, tgt_d;
    logic               vld_q, vld_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [DIGIT_W-1:0] cand;
    logic               accept;

    assign cand = lfsr[DIGIT_W-1:0];

    always_comb begin
        accept = (cand <= MAX_DIGIT);
`ifdef TARGET_GEN_DISTINCT_EN
        if (state_q == D2 && cand == dig3_q)                    accept = 1'b0;
        if (state_q == D3 && (cand == dig3_q || cand == dig2_q)) accept = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        dig3_d  = dig3_q;
        dig2_d  = dig2_q;
        tgt_d   = tgt_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (state_q != IDLE && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        case (state_q)
            IDLE: if (gen_req) begin
                state_d = D1;
                vld_d   = 1'b0;
                cnt_d   = 8'd0;
            end
            D1: if (accept) begin
                dig3_d  = cand;
                state_d = D2;
            end
            D2: if (accept) begin
                dig2_d  = cand;
                state_d = D3;
            end
            D3: if (accept) begin
                // All three digits land in target_number on the same edge.
                tgt_d   = {dig3_q, dig2_q, cand};
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dig3_q  <= '0;
            dig2_q  <= '0;
            tgt_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dig3_q  <= dig3_d;
            dig2_q  <= dig2_d;
            tgt_q   <= tgt_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign target_number = tgt_q;
    assign target_valid  = vld_q;
    assign busy          = (state_q != IDLE);
    assign draw_count    = cnt_q;

endmodule

// File: tb/tb_target_gen.sv
module tb_target_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_req = 1'b0;
    logic [11:0] target_number, z_target;
    logic        target_valid, busy, z_valid, z_busy;
    logic [7:0]  draw_count, z_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    target_gen #(.LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .gen_req(gen_req),
        .target_number(target_number), .target_valid(target_valid),
        .busy(busy), .draw_count(draw_count)
    );

    target_gen #(.LFSR_SEED(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .gen_req(gen_req),
        .target_number(z_target), .target_valid(z_valid),
        .busy(z_busy), .draw_count(z_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Draw candidates from LFSR state s (state seen on the first draw cycle)
    // until three digits are accepted; return target and number of draws.
    function automatic void gen(input logic [15:0] s, output logic [11:0] t, output int n);
        logic [3:0] dg [3];
        int         k;
        logic [3:0] c;
        bit         ok;
        k = 0; n = 0;
        dg[0] = 0; dg[1] = 0; dg[2] = 0;
        while (k < 3 && n < 100000) begin
            c  = s[3:0];
            n++;
            ok = (c <= 4'd9);
`ifdef TARGET_GEN_DISTINCT_EN
            for (int j = 0; j < k; j++) if (dg[j] == c) ok = 0;
`endif
            if (ok) begin dg[k] = c; k++; end
            s = step(s);
        end
        t = {dg[0], dg[1], dg[2]};
    endfunction

    logic [15:0] m_lfsr = 16'hACE1;
    logic        m_busy = 0, m_valid = 0;
    logic [11:0] m_tgt = 0, pend_tgt = 0;
    logic [7:0]  m_cnt = 0;
    int          remaining = 0;

    always @(posedge clk) begin
        logic [15:0] nxt;
        if (rst) begin
            m_lfsr = 16'hACE1; m_busy = 0; m_valid = 0; m_tgt = 0; m_cnt = 0;
        end else begin
            nxt = step(m_lfsr);
            if (m_busy) begin
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                remaining--;
                if (remaining == 0) begin m_busy = 0; m_valid = 1; m_tgt = pend_tgt; end
            end else if (gen_req) begin
                m_busy = 1; m_valid = 0; m_cnt = 0;
                gen(nxt, pend_tgt, remaining);
            end
            m_lfsr = nxt;
        end
    end

    // ---------------- compare process ----------------
    bit   chk_en = 0;
    int   done_cnt = 0, z_done = 0;
    logic prev_valid = 0, z_prev = 0;
    bit   seen_rep = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lfsr",   32'(dut.lfsr),    32'(m_lfsr));
            chk("busy",   32'(busy),        32'(m_busy));
            chk("valid",  32'(target_valid), 32'(m_valid));
            chk("target", 32'(target_number), 32'(m_tgt));
            chk("count",  32'(draw_count),  32'(m_cnt));
            if (target_valid) begin
                chk("bcd", 32'((target_number[11:8] <= 9) && (target_number[7:4] <= 9)
                               && (target_number[3:0] <= 9)), 32'(1));
`ifdef TARGET_GEN_DISTINCT_EN
                chk("distinct", 32'((target_number[11:8] != target_number[7:4]) &&
                                    (target_number[11:8] != target_number[3:0]) &&
                                    (target_number[7:4]  != target_number[3:0])), 32'(1));
`else
                if ((target_number[11:8] == target_number[7:4]) ||
                    (target_number[11:8] == target_number[3:0]) ||
                    (target_number[7:4]  == target_number[3:0])) seen_rep = 1;
`endif
            end
            if (target_valid && !prev_valid) done_cnt++;
            if (z_valid && !z_prev) begin
                z_done++;
                chk("zseed_bcd", 32'((z_target[11:8] <= 9) && (z_target[7:4] <= 9)
                                     && (z_target[3:0] <= 9)), 32'(1));
            end
        end
        prev_valid = target_valid;
        z_prev     = z_valid;
    end

    task automatic wait_done(input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (target_valid) begin got = 1; break; end
        end
        if (!got) chk("timeout", 32'(0), 32'(1));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        // Reset held two cycles; LFSRs sit at their seeds.
        tick(); chk_en = 1;
        tick();
        @(negedge clk);
        chk("rst_lfsr",  32'(dut.lfsr),  32'h0000ACE1);
        chk("rst_zlfsr", 32'(dut0.lfsr), 32'h00000001);
        chk("rst_tgt",   32'(target_number), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);

        // Single request sampled on the first edge after release.
        // Hand trace: draws 3,7,F,E,C,9 -> target 379 after 6 draws.
        @(posedge clk); #1; rst = 0; gen_req = 1;
        @(posedge clk); #1; gen_req = 0;
        @(negedge clk);
        chk("lit_lfsr1", 32'(dut.lfsr), 32'h000059C3);
        chk("lit_busy",  32'(busy), 32'h1);
        @(negedge clk);
        chk("lit_lfsr2", 32'(dut.lfsr), 32'h0000B387);
        wait_done(50);
        chk("lit_target", 32'(target_number), 32'h379);
        chk("lit_count",  32'(draw_count), 32'd6);
        repeat (3) tick();

        // Request while busy: second pulse ignored, one completion.
        d0 = done_cnt;
        gen_req = 1;
        tick(); tick();
        gen_req = 0;
        wait_done(200);
        repeat (5) tick();
        chk("busy_req_done", 32'(done_cnt - d0), 32'd1);

        // Reset mid-generation.
        gen_req = 1;
        tick();
        gen_req = 0; rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy",  32'(busy), 32'h0);
        chk("mid_valid", 32'(target_valid), 32'h0);
        chk("mid_tgt",   32'(target_number), 32'h0);
        tick(); rst = 0;
        tick();
        gen_req = 1; tick(); gen_req = 0;
        wait_done(200);
        chk("post_rst_valid", 32'(target_valid), 32'h1);

        // Soak: gen_req held high back to back.
        d0 = done_cnt;
        gen_req = 1;
        for (int i = 0; i < 60000 && (done_cnt - d0) < 2000; i++) tick();
        gen_req = 0;
        chk("soak_done", 32'((done_cnt - d0) >= 2000), 32'(1));
        repeat (300) tick();
        chk("soak_idle", 32'(busy), 32'h0);
`ifndef TARGET_GEN_DISTINCT_EN
        chk("soak_repeat_seen", 32'(seen_rep), 32'(1));
`endif
        chk("zseed_progress", 32'(z_done > 0), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
